// File: rtl/mem_ctrl.sv
// Memory-access stage: runs one req/gnt/rvalid transaction per memory op,
// aligns/extends load data and registers writeback fields into mem/wb.
module mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] inst_i,
  input  logic [31:0] instaddr_i,
  input  logic        cs_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_wem_i,
  input  logic [31:0] mem_din_i,
  input  logic [31:0] mem_addr_i,
  input  logic        regs_wen_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [3:0]  dbus_wem_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] instaddr_o,
  output logic        regs_wen_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        mem_hold_flag_o,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               cap_we;
  logic [3:0]         cap_wem;
  logic [31:0]        cap_wdata;
  logic [31:0]        cap_addr;
  logic [2:0]         cap_funct3;
  logic [31:0]        cap_inst;
  logic [31:0]        cap_instaddr;
  logic               cap_regs_wen;
  logic [4:0]         cap_rd_addr;
  logic               timeout_c;
  logic               done_c;
  logic               abort_c;
  logic [7:0]         byte_c;
  logic [15:0]        half_c;
  logic [31:0]        load_data_c;

  // >= so a load granted on the timeout cycle still aborts from RESP
  assign timeout_c = (cnt >= 8'(TIMEOUT - 1));

  assign dbus_we_o    = cap_we;
  assign dbus_wem_o   = cap_wem;
  assign dbus_addr_o  = {cap_addr[31:2], 2'b00};
  assign dbus_wdata_o = cap_wdata;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cs_i) state_nxt = REQ;
      REQ: begin
        if (dbus_gnt_i && !cap_we) state_nxt = RESP;
        else if (done_c || abort_c) state_nxt = IDLE;
      end
      RESP: if (done_c || abort_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Completion/abort decode and stall flag; completion beats timeout
  always_comb begin
    done_c          = 1'b0;
    abort_c         = 1'b0;
    mem_hold_flag_o = 1'b0;
    unique case (state)
      IDLE: mem_hold_flag_o = cs_i;
      REQ: begin
        done_c          = dbus_gnt_i && cap_we;
        abort_c         = !dbus_gnt_i && timeout_c;
        mem_hold_flag_o = !(done_c || abort_c);
      end
      RESP: begin
        done_c          = dbus_rvalid_i;
        abort_c         = !dbus_rvalid_i && timeout_c;
        mem_hold_flag_o = !(done_c || abort_c);
      end
      default: mem_hold_flag_o = 1'b0;
    endcase
  end

  // Load alignment and extension
  always_comb begin
    byte_c      = 8'(dbus_rdata_i >> {cap_addr[1:0], 3'b000});
    half_c      = cap_addr[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    load_data_c = 32'd0;
    case (cap_funct3)
      3'd0:    load_data_c = {{24{byte_c[7]}}, byte_c};
      3'd4:    load_data_c = {24'd0, byte_c};
      3'd1:    load_data_c = {{16{half_c[15]}}, half_c};
      3'd5:    load_data_c = {16'd0, half_c};
      3'd2:    load_data_c = dbus_rdata_i;
      default: load_data_c = 32'd0;
    endcase
  end

  // Request capture and bus request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_we       <= 1'b0;
      cap_wem      <= 4'd0;
      cap_wdata    <= 32'd0;
      cap_addr     <= 32'd0;
      cap_funct3   <= 3'd0;
      cap_inst     <= 32'd0;
      cap_instaddr <= 32'd0;
      cap_regs_wen <= 1'b0;
      cap_rd_addr  <= 5'd0;
      dbus_req_o   <= 1'b0;
      cnt          <= '0;
    end else begin
      dbus_req_o <= (state_nxt == REQ);
      if (state == IDLE) begin
        cnt <= '0;
        if (cs_i) begin
          cap_we       <= mem_we_i;
          cap_wem      <= mem_wem_i;
          cap_wdata    <= mem_din_i;
          cap_addr     <= mem_addr_i;
          cap_funct3   <= inst_i[14:12];
          cap_inst     <= inst_i;
          cap_instaddr <= instaddr_i;
          cap_regs_wen <= regs_wen_i;
          cap_rd_addr  <= rd_addr_i;
        end
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // mem/wb output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_o     <= 32'd0;
      instaddr_o <= 32'd0;
      regs_wen_o <= 1'b0;
      rd_addr_o  <= 5'd0;
      rd_data_o  <= 32'd0;
      bus_err_o  <= 1'b0;
    end else begin
      bus_err_o <= abort_c;
      if (state == IDLE) begin
        if (cs_i) begin
          regs_wen_o <= 1'b0;
        end else begin
          inst_o     <= inst_i;
          instaddr_o <= instaddr_i;
          regs_wen_o <= regs_wen_i;
          rd_addr_o  <= rd_addr_i;
          rd_data_o  <= rd_data_i;
        end
      end else if (done_c) begin
        inst_o     <= cap_inst;
        instaddr_o <= cap_instaddr;
        rd_addr_o  <= cap_rd_addr;
        regs_wen_o <= cap_we ? 1'b0 : cap_regs_wen;
        rd_data_o  <= cap_we ? 32'd0 : load_data_c;
      end else if (abort_c) begin
        regs_wen_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected writebacks, a
// negedge monitor pops them whenever the DUT presents a writeback or abort.
module tb_mem_ctrl;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] inst_i, instaddr_i, mem_din_i, mem_addr_i, rd_data_i, dbus_rdata_i;
  logic        cs_i, mem_we_i, regs_wen_i, dbus_gnt_i, dbus_rvalid_i;
  logic [3:0]  mem_wem_i;
  logic [4:0]  rd_addr_i;
  logic        dbus_req_o, dbus_we_o, regs_wen_o, mem_hold_flag_o, bus_err_o;
  logic [3:0]  dbus_wem_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, inst_o, instaddr_o, rd_data_o;
  logic [4:0]  rd_addr_o;

  typedef struct packed {
    logic        is_err;
    logic [31:0] inst;
    logic [31:0] instaddr;
    logic [4:0]  rd_addr;
    logic        regs_wen;
    logic [31:0] rd_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .inst_i(inst_i), .instaddr_i(instaddr_i),
    .cs_i(cs_i), .mem_we_i(mem_we_i), .mem_wem_i(mem_wem_i), .mem_din_i(mem_din_i),
    .mem_addr_i(mem_addr_i), .regs_wen_i(regs_wen_i), .rd_addr_i(rd_addr_i),
    .rd_data_i(rd_data_i), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_wem_o(dbus_wem_o), .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
    .inst_o(inst_o), .instaddr_o(instaddr_o), .regs_wen_o(regs_wen_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .mem_hold_flag_o(mem_hold_flag_o),
    .bus_err_o(bus_err_o)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a new nonzero instaddr_o marks a writeback, bus_err_o an abort
  logic [31:0] prev_ia = 32'd0;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      prev_ia = 32'd0;
    end else begin
      if (bus_err_o || (instaddr_o != prev_ia && instaddr_o != 32'd0)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: instaddr_o %h bus_err_o %b with empty scoreboard",
                   instaddr_o, bus_err_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_bus_err", 32'(bus_err_o), 32'(e.is_err));
          check("sb_regs_wen", 32'(regs_wen_o), 32'(e.regs_wen));
          if (!e.is_err) begin
            check("sb_inst", inst_o, e.inst);
            check("sb_instaddr", instaddr_o, e.instaddr);
            check("sb_rd_addr", 32'(rd_addr_o), 32'(e.rd_addr));
            check("sb_rd_data", rd_data_o, e.rd_data);
          end
        end
      end
      prev_ia = instaddr_o;
    end
  end

  task automatic idle_inputs();
    cs_i = 1'b0; mem_we_i = 1'b0; mem_wem_i = 4'd0; mem_din_i = 32'd0; mem_addr_i = 32'd0;
    inst_i = 32'd0; instaddr_i = 32'd0; regs_wen_i = 1'b0; rd_addr_i = 5'd0; rd_data_i = 32'd0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'd0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic [31:0] ia, input logic [4:0] rd, input logic [31:0] d);
    cs_i = 1'b0; inst_i = 32'h0000_0033 | (32'(rd) << 7); instaddr_i = ia;
    rd_addr_i = rd; rd_data_i = d; regs_wen_i = 1'b1;
    exp_q.push_back('{is_err: 1'b0, inst: inst_i, instaddr: ia, rd_addr: rd,
                      regs_wen: 1'b1, rd_data: d});
    @(negedge clk);
    check("alu_hold", 32'(mem_hold_flag_o), 32'd0);
    next_cyc();
  endtask

  task automatic set_mem(input logic we, input logic [3:0] wem, input logic [31:0] din,
                         input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                         input logic wen, input logic [31:0] ia);
    cs_i = 1'b1; mem_we_i = we; mem_wem_i = wem; mem_din_i = din; mem_addr_i = addr;
    inst_i = {17'd0, f3, rd, (we ? 7'h23 : 7'h03)}; instaddr_i = ia;
    regs_wen_i = wen; rd_addr_i = rd; rd_data_i = 32'h5555_5555;
  endtask

  task automatic mem_op(input string nm, input logic we, input logic [3:0] wem,
                        input logic [31:0] din, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [4:0] rd, input logic wen, input logic [31:0] ia,
                        input int gd, input int rvd, input logic [31:0] rdata,
                        input logic [31:0] exp_data);
    int   hold_n = 0;
    int   req_n  = 0;
    logic bad    = 1'b0;
    set_mem(we, wem, din, addr, f3, rd, wen, ia);
    exp_q.push_back('{is_err: 1'b0, inst: inst_i, instaddr: ia, rd_addr: rd,
                      regs_wen: (we ? 1'b0 : wen), rd_data: (we ? 32'd0 : exp_data)});
    @(negedge clk);
    hold_n += int'(mem_hold_flag_o);
    next_cyc();
    for (int c = 0; c <= gd; c++) begin
      dbus_gnt_i = (c == gd);
      @(negedge clk);
      hold_n += int'(mem_hold_flag_o);
      req_n  += int'(dbus_req_o);
      if (dbus_addr_o !== {addr[31:2], 2'b00} || dbus_we_o !== we ||
          dbus_wem_o !== wem || dbus_wdata_o !== din) bad = 1'b1;
      next_cyc();
    end
    dbus_gnt_i = 1'b0;
    if (!we) begin
      for (int c = 0; c <= rvd; c++) begin
        dbus_rvalid_i = (c == rvd);
        dbus_rdata_i  = (c == rvd) ? rdata : 32'h0F0F_0F0F;
        @(negedge clk);
        hold_n += int'(mem_hold_flag_o);
        req_n  += int'(dbus_req_o);
        if (dbus_addr_o !== {addr[31:2], 2'b00}) bad = 1'b1;
        next_cyc();
      end
    end
    idle_inputs();
    check({nm, "_hold_cycles"}, 32'(hold_n), we ? 32'(1 + gd) : 32'(2 + gd + rvd));
    check({nm, "_req_cycles"}, 32'(req_n), 32'(gd + 1));
    check({nm, "_bus_fields"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int req_n;
    int hold_n;
    idle_inputs();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_regs_wen", 32'(regs_wen_o), 32'd0);
    check("rst_rd_data", rd_data_o, 32'd0);
    check("rst_instaddr", instaddr_o, 32'd0);
    check("rst_dbus_req", 32'(dbus_req_o), 32'd0);
    check("rst_bus_err", 32'(bus_err_o), 32'd0);
    check("rst_hold", 32'(mem_hold_flag_o), 32'd0);
    rstn = 1'b1;
    next_cyc();

    alu_op(32'h0000_1000, 5'd5, 32'h1234_5678);
    idle_inputs();
    next_cyc();

    mem_op("lb",   1'b0, 4'h0, 32'd0, 32'h103, 3'd0, 5'd7,  1'b1, 32'h1004, 0, 0,
           32'h80FF_0000, 32'hFFFF_FF80);
    mem_op("lbu",  1'b0, 4'h0, 32'd0, 32'h201, 3'd4, 5'd8,  1'b1, 32'h1008, 1, 1,
           32'h1234_5678, 32'h0000_0056);
    mem_op("lhu",  1'b0, 4'h0, 32'd0, 32'h302, 3'd5, 5'd9,  1'b1, 32'h100C, 0, 0,
           32'hABCD_1234, 32'h0000_ABCD);
    mem_op("lh",   1'b0, 4'h0, 32'd0, 32'h400, 3'd1, 5'd10, 1'b1, 32'h1010, 0, 2,
           32'h1234_8001, 32'hFFFF_8001);
    mem_op("lw",   1'b0, 4'h0, 32'd0, 32'h504, 3'd2, 5'd11, 1'b1, 32'h1014, 0, 5,
           32'hCAFE_F00D, 32'hCAFE_F00D);
    mem_op("sw",   1'b1, 4'hF, 32'hDEAD_BEEF, 32'h508, 3'd2, 5'd12, 1'b1, 32'h1018, 3, 0,
           32'd0, 32'd0);
    mem_op("bad_f3", 1'b0, 4'h0, 32'd0, 32'h600, 3'd3, 5'd13, 1'b1, 32'h101C, 0, 0,
           32'hFFFF_FFFF, 32'h0000_0000);

    // Timeout: gnt never arrives
    set_mem(1'b0, 4'h0, 32'd0, 32'h800, 3'd2, 5'd14, 1'b1, 32'h1020);
    exp_q.push_back('{is_err: 1'b1, inst: 32'd0, instaddr: 32'd0, rd_addr: 5'd0,
                      regs_wen: 1'b0, rd_data: 32'd0});
    @(negedge clk);
    next_cyc();
    req_n = 0;
    hold_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_n  += int'(dbus_req_o);
      hold_n += int'(mem_hold_flag_o);
      if (!mem_hold_flag_o) break;
      next_cyc();
    end
    next_cyc();
    idle_inputs();
    check("to_req_cycles", 32'(req_n), 32'(TO));
    check("to_hold_cycles", 32'(hold_n), 32'(TO - 1));
    @(negedge clk);
    check("to_bus_err", 32'(bus_err_o), 32'd1);
    check("to_req_dropped", 32'(dbus_req_o), 32'd0);
    check("to_hold_dropped", 32'(mem_hold_flag_o), 32'd0);
    next_cyc();
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'h7777_7777;
    @(negedge clk);
    check("to_err_one_pulse", 32'(bus_err_o), 32'd0);
    next_cyc();
    idle_inputs();
    @(negedge clk);
    check("late_rvalid_regs_wen", 32'(regs_wen_o), 32'd0);
    check("late_rvalid_hold", 32'(mem_hold_flag_o), 32'd0);
    next_cyc();

    // Reset while in RESP
    alu_op(32'h0000_2000, 5'd9, 32'hA5A5_0001);
    set_mem(1'b0, 4'h0, 32'd0, 32'h900, 3'd2, 5'd15, 1'b1, 32'h2004);
    next_cyc();
    dbus_gnt_i = 1'b1;
    next_cyc();
    dbus_gnt_i = 1'b0;
    @(negedge clk);
    check("resp_hold", 32'(mem_hold_flag_o), 32'd1);
    check("resp_rd_data_prior", rd_data_o, 32'hA5A5_0001);
    #1;
    rstn = 1'b0;
    idle_inputs();
    #1;
    check("rst_mid_req", 32'(dbus_req_o), 32'd0);
    check("rst_mid_rd_data", rd_data_o, 32'd0);
    check("rst_mid_instaddr", instaddr_o, 32'd0);
    check("rst_mid_hold", 32'(mem_hold_flag_o), 32'd0);
    next_cyc();
    rstn = 1'b1;
    next_cyc();
    mem_op("lw_after_rst", 1'b0, 4'h0, 32'd0, 32'h704, 3'd2, 5'd16, 1'b1, 32'h3000, 0, 0,
           32'h0BAD_CAFE, 32'h0BAD_CAFE);

    repeat (3) next_cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory-access stage directly downstream of the execute stage, fed through the ex/mem pipeline register.
- Takes the execute stage's chip-select, write-enable, byte-mask, write data and address, and runs a req/gnt/rvalid transaction on the data bus.
- Aligns and sign- or zero-extends load data, then registers the writeback fields into mem/wb.
- Raises a hold flag to ctrl while a transaction is outstanding; non-memory instructions pass through with one cycle of latency.

Parameters:
- TIMEOUT, 255: max cycles in REQ+RESP before abort (1..255, 8-bit counter).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- inst_i  in  32  instruction from ex/mem
- instaddr_i  in  32  instruction address
- cs_i  in  1  memory access request
- mem_we_i  in  1  1=store, 0=load
- mem_wem_i  in  4  store byte mask (already lane-aligned upstream)
- mem_din_i  in  32  store data (already lane-aligned upstream)
- mem_addr_i  in  32  byte address
- regs_wen_i  in  1  register write enable
- rd_addr_i  in  5  destination register
- rd_data_i  in  32  ALU result
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  bus write
- dbus_wem_o  out  4  bus byte mask
- dbus_addr_o  out  32  bus address, word-aligned ({addr[31:2],2'b00})
- dbus_wdata_o  out  32  bus write data
- dbus_gnt_i  in  1  request accepted
- dbus_rvalid_i  in  1  read data valid
- dbus_rdata_i  in  32  read word
- inst_o  out  32  to mem/wb
- instaddr_o  out  32  to mem/wb
- regs_wen_o  out  1  to mem/wb
- rd_addr_o  out  5  to mem/wb
- rd_data_o  out  32  to mem/wb
- mem_hold_flag_o  out  1  to ctrl: stall ex/mem and upstream
- bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values: all registered outputs are 0; state=IDLE; dbus_req_o=0; counter=0.
- States: IDLE, REQ, RESP.
- IDLE with cs_i=0:
  - mem_hold_flag_o=0.
  - At the edge, inst/instaddr/regs_wen/rd_addr/rd_data are registered to outputs (latency 1).
- IDLE with cs_i=1:
  - mem_hold_flag_o=1 combinationally.
  - Capture we, wem, wdata, addr, funct3=inst_i[14:12], inst, instaddr, regs_wen, rd_addr into internal registers.
  - Go to REQ. Output registers load regs_wen_o=0 (bubble).
- REQ:
  - dbus_req_o=1 and bus fields are driven from the captured registers, held stable until gnt.
  - gnt with store: complete.
  - gnt with load: go to RESP.
  - rvalid in REQ is ignored.
- RESP: on rvalid, complete with load data.
- Completion cycle:
  - mem_hold_flag_o=0 combinationally in that same cycle.
  - At the edge: outputs take the captured inst, instaddr, rd_addr and regs_wen, and state goes to IDLE.
  - Load: rd_data_o = extended data.
  - Store: rd_data_o=0 and regs_wen_o=0.
  - The next ex/mem contents appear the cycle after. Back-to-back memory ops therefore cost at least 3 cycles each (IDLE, REQ, RESP) with zero-wait gnt/rvalid.
- Load extension, with b = addr[1:0]:
  - LB (0): sign-extend byte lane b.
  - LBU (4): zero-extend byte lane b.
  - LH (1): sign-extend half selected by addr[1].
  - LHU (5): zero-extend half selected by addr[1].
  - LW (2): full word.
  - Other funct3: 0.
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT without completion: abort, bus_err_o=1 for one cycle, regs_wen_o=0, hold drops, state goes to IDLE.
  - An outstanding rvalid arriving later while in IDLE is ignored.
- Simultaneous gnt and timeout on the same cycle: completion wins.
- Reset mid-transaction: immediate IDLE, dbus_req_o=0, no writeback.
- mem_hold_flag_o is never asserted in IDLE when cs_i=0.

Test Plan:
- ALU passthrough: cs_i=0, rd_data_i=32'h1234_5678, rd_addr_i=5, regs_wen_i=1 -> next cycle rd_data_o=32'h1234_5678, rd_addr_o=5, hold never 1.
- LB sign-extend: addr=32'h100 + 3, funct3=0, gnt at first REQ cycle, rvalid next cycle with rdata=32'h80FF_0000 -> dbus_addr_o=32'h100, rd_data_o=32'hFFFF_FF80, hold high exactly 2 cycles.
- LHU: addr offset 2, rdata=32'hABCD_1234 -> rd_data_o=32'h0000_ABCD. LW with rvalid delayed 5 cycles -> hold remains 1 and bus fields are stable throughout.
- Store SW: wem=4'b1111, din=32'hDEAD_BEEF, gnt delayed 3 cycles -> dbus_req_o held 3+1 cycles, regs_wen_o=0 at completion, no RESP state.
- Timeout: TIMEOUT=8, gnt never asserted -> after 8 REQ cycles bus_err_o pulses once, dbus_req_o drops, regs_wen_o=0, hold drops.
- Reset mid-op: assert rstn=0 while in RESP -> dbus_req_o=0, all outputs 0 asynchronously; after release, a following load completes normally.
